// File: rtl/deser_pkg.sv
// Shared types and sizing for the 1:N serial deserializer.
package deser_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CNT_W      = $clog2(DATA_W_DEF + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } deser_state_e;

   // Bit-counter width able to hold the value data_w.
   function automatic int cnt_width(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/deser_out_buf.sv
// Single-entry valid/ready holding register with sticky overflow flag.
// A load arriving while full is dropped unless the consumer takes the old
// word in the same cycle.
module deser_out_buf #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         rd_ready,
   input  logic         ovf_clr,
   output logic [W-1:0] data,
   output logic         valid,
   output logic         ovf
);

   logic [W-1:0] data_q, data_d;
   logic         valid_q, valid_d;
   logic         ovf_q, ovf_d;
   logic         ovf_set;

   // Buffer occupancy, data capture and overflow detection.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovf_set = 1'b0;
      if (load) begin
         if (!valid_q || rd_ready) begin
            data_d  = load_data;
            valid_d = 1'b1;
         end else begin
            ovf_set = 1'b1;
         end
      end else if (valid_q && rd_ready) begin
         valid_d = 1'b0;
      end
      // A new overflow in the clearing cycle must not be lost.
      ovf_d = ovf_set | (ovf_q & ~ovf_clr);
   end

   // Buffer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;
   assign ovf   = ovf_q;

endmodule

// File: rtl/deserializer_1to32_sr.sv
// Serial-to-parallel receiver, MSB first, framed by frame_start.
// Optional even-parity trailer bit enabled by defining DESER_PARITY_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for frame_start; serial_in ignored
// ST_SHIFT  | collecting data bits; cnt = bits already captured
// ST_PARITY | sampling the parity bit after the LSB (DESER_PARITY_EN only)
module deserializer_1to32_sr
   import deser_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              serial_in,
   input  logic              frame_start,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_par_err,
   output logic              ovf,
   input  logic              ovf_clr
);

   localparam int                 CNT_BITS = cnt_width(DATA_W);
   localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(DATA_W - 1);

   deser_state_e        state_q, state_d;
   logic [DATA_W-1:0]   sr_q, sr_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0]   sr_shift;
   logic                word_done;
   logic [DATA_W-1:0]   word;
   logic                word_err;
   logic [DATA_W:0]     buf_data;

   assign sr_shift = {sr_q[DATA_W-2:0], serial_in};

   // State, shift register and bit counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; frame_start always restarts a frame.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (frame_start) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (frame_start) begin
               state_d = ST_SHIFT;
            end else if (cnt_q == LAST_CNT) begin
`ifdef DESER_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_IDLE;
`endif
            end
         end
         ST_PARITY: begin
            state_d = frame_start ? ST_SHIFT : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath updates and word-completion strobe.
   always_comb begin
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      word_done = 1'b0;
      word      = sr_shift;
      word_err  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               sr_d  = sr_shift;
               cnt_d = CNT_BITS'(1);
            end
         end
         ST_SHIFT: begin
            sr_d = sr_shift;
            if (frame_start) begin
               cnt_d = CNT_BITS'(1);
            end else if (cnt_q == LAST_CNT) begin
               cnt_d = '0;
`ifndef DESER_PARITY_EN
               word_done = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_PARITY: begin
            if (frame_start) begin
               sr_d  = sr_shift;
               cnt_d = CNT_BITS'(1);
            end else begin
`ifdef DESER_PARITY_EN
               // Data is already complete in sr_q; serial_in is the parity bit.
               word_done = 1'b1;
               word      = sr_q;
               word_err  = ^{sr_q, serial_in};
`endif
            end
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   // Parity error rides in the top bit so it is loaded together with the word.
   deser_out_buf #(
      .W (DATA_W + 1)
   ) u_out_buf (
      .clk       (clk),
      .reset     (reset),
      .load      (word_done),
      .load_data ({word_err, word}),
      .rd_ready  (out_ready),
      .ovf_clr   (ovf_clr),
      .data      (buf_data),
      .valid     (out_valid),
      .ovf       (ovf)
   );

   assign out_data    = buf_data[DATA_W-1:0];
   assign out_par_err = buf_data[DATA_W];

endmodule
